brick_game_ctrl: RTL

Game sequencer for the brick-breaker display path. It owns paddle position, ball position and direction, lives and game state. It advances them once per internal motion tick and presents registered coordinates to the pixel-colouring logic that sits beside the VGA driver. It replaces ad-hoc per-object movement logic with one scheduler, so paddle and ball always update on the same tick.

---
 rtl/brick_pkg.sv | 19 +
 rtl/motion_tick_gen.sv | 35 +++
 rtl/brick_game_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/brick_pkg.sv
// Shared types and default geometry for the brick-breaker game sequencer.
// Optional BRICK_PADDLE_SPIN_EN (used by brick_game_ctrl) adds contact-point steering on paddle hits.
package brick_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } game_state_t;

    localparam int DEF_TICK_DIV = 277777;
    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;
    localparam int DEF_PADDLE_W = 100;
    localparam int DEF_PADDLE_Y = 440;
    localparam int DEF_BALL_SZ  = 8;
    localparam int DEF_LIVES    = 3;

endpackage

// File: rtl/motion_tick_gen.sv
// Free-running motion tick: counts 0..TICK_DIV, tick is high while the count sits at TICK_DIV.
module motion_tick_gen
    import brick_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_DIV < 1) ? 1 : $clog2(TICK_DIV + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // tick_d looks at the next count so the registered pulse coincides with count == TICK_DIV
    always_comb begin
        cnt_d  = (cnt_q == CW'(TICK_DIV)) ? '0 : cnt_q + CW'(1);
        tick_d = (cnt_d == CW'(TICK_DIV));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/brick_game_ctrl.sv
// Brick-breaker game sequencer: paddle, ball, lives and game state advanced on a shared motion tick.
// Define BRICK_PADDLE_SPIN_EN to let a paddle hit steer dx from the contact point.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | ball parked on paddle, waiting for serve
// ST_PLAY | ball in flight, bounces and misses evaluated
// ST_OVER | no lives left, everything frozen until serve
module brick_game_ctrl
    import brick_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int PADDLE_W = DEF_PADDLE_W,
    parameter int PADDLE_Y = DEF_PADDLE_Y,
    parameter int BALL_SZ  = DEF_BALL_SZ,
    parameter int LIVES    = DEF_LIVES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       serve,
    output logic [9:0] paddle_x,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [1:0] state,
    output logic [1:0] lives,
    output logic       tick,
    output logic       miss
);

    localparam logic [9:0] PAD_MAX = 10'(SCREEN_W - PADDLE_W);
    localparam logic [9:0] PAD_CTR = 10'((SCREEN_W - PADDLE_W) / 2);
    localparam logic [9:0] PARK_DX = 10'(PADDLE_W / 2 - BALL_SZ / 2);
    localparam logic [9:0] PARK_Y  = 10'(PADDLE_Y - BALL_SZ);
    localparam logic [9:0] X_MAX   = 10'(SCREEN_W - BALL_SZ);
    localparam logic [9:0] Y_MAX   = 10'(SCREEN_H - BALL_SZ);
    localparam logic [9:0] BSZ     = 10'(BALL_SZ);
    localparam logic [9:0] PW      = 10'(PADDLE_W);
    localparam logic [1:0] LIVES_INIT = 2'(LIVES);

    game_state_t state_q, state_d;
    logic [9:0]  paddle_x_q, paddle_x_d;
    logic [9:0]  ball_x_q, ball_x_d;
    logic [9:0]  ball_y_q, ball_y_d;
    logic        dx_neg_q, dx_neg_d;
    logic        dy_neg_q, dy_neg_d;
    logic [1:0]  lives_q, lives_d;
    logic        miss_q, miss_d;

    logic        tick_w;
    logic [9:0]  paddle_nx;
    logic        wall_x, hit, miss_cond, ndx_neg, ndy_neg;

    motion_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_w)
    );

    always_comb begin
        paddle_nx = paddle_x_q;
        if (key_left && !key_right && paddle_x_q != 10'd0)
            paddle_nx = paddle_x_q - 10'd1;
        else if (key_right && !key_left && paddle_x_q < PAD_MAX)
            paddle_nx = paddle_x_q + 10'd1;

        // bounce decisions use the pre-tick paddle and ball positions
        wall_x    = (ball_x_q == 10'd0 && dx_neg_q) || (ball_x_q == X_MAX && !dx_neg_q);
        hit       = !dy_neg_q && (ball_y_q + BSZ == 10'(PADDLE_Y)) &&
                    (ball_x_q + BSZ > paddle_x_q) && (ball_x_q < paddle_x_q + PW);
        miss_cond = (ball_y_q == Y_MAX) && !dy_neg_q;

        ndx_neg = wall_x ? !dx_neg_q : dx_neg_q;
`ifdef BRICK_PADDLE_SPIN_EN
        if (hit && !wall_x)
            ndx_neg = (ball_x_q + BSZ / 10'd2) < (paddle_x_q + PW / 10'd2);
`endif
        ndy_neg = dy_neg_q;
        if (ball_y_q == 10'd0 && dy_neg_q)
            ndy_neg = 1'b0;
        else if (hit)
            ndy_neg = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        paddle_x_d = paddle_x_q;
        ball_x_d   = ball_x_q;
        ball_y_d   = ball_y_q;
        dx_neg_d   = dx_neg_q;
        dy_neg_d   = dy_neg_q;
        lives_d    = lives_q;
        miss_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (tick_w)
                    paddle_x_d = paddle_nx;
                ball_x_d = paddle_x_d + PARK_DX;
                ball_y_d = PARK_Y;
                if (serve) begin
                    state_d  = ST_PLAY;
                    dx_neg_d = 1'b0;
                    dy_neg_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (tick_w) begin
                    paddle_x_d = paddle_nx;
                    if (miss_cond) begin
                        miss_d  = 1'b1;
                        lives_d = lives_q - 2'd1;
                        state_d = (lives_q == 2'd1) ? ST_OVER : ST_IDLE;
                    end else begin
                        dx_neg_d = ndx_neg;
                        dy_neg_d = ndy_neg;
                        ball_x_d = ndx_neg ? ball_x_q - 10'd1 : ball_x_q + 10'd1;
                        ball_y_d = ndy_neg ? ball_y_q - 10'd1 : ball_y_q + 10'd1;
                    end
                end
            end
            ST_OVER: begin
                if (serve) begin
                    state_d    = ST_IDLE;
                    lives_d    = LIVES_INIT;
                    paddle_x_d = PAD_CTR;
                    ball_x_d   = PAD_CTR + PARK_DX;
                    ball_y_d   = PARK_Y;
                    dx_neg_d   = 1'b0;
                    dy_neg_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            paddle_x_q <= PAD_CTR;
            ball_x_q   <= PAD_CTR + PARK_DX;
            ball_y_q   <= PARK_Y;
            dx_neg_q   <= 1'b0;
            dy_neg_q   <= 1'b1;
            lives_q    <= LIVES_INIT;
            miss_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            paddle_x_q <= paddle_x_d;
            ball_x_q   <= ball_x_d;
            ball_y_q   <= ball_y_d;
            dx_neg_q   <= dx_neg_d;
            dy_neg_q   <= dy_neg_d;
            lives_q    <= lives_d;
            miss_q     <= miss_d;
        end
    end

    assign paddle_x = paddle_x_q;
    assign ball_x   = ball_x_q;
    assign ball_y   = ball_y_q;
    assign state    = state_q;
    assign lives    = lives_q;
    assign tick     = tick_w;
    assign miss     = miss_q;

endmodule
